// File: rtl/prog_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : prog_seq_pkg
//  Purpose  : Shared types and constants for the program sequencer.
//             - seq_state_t     : sequencer state encoding
//             - LAUNCH_CNT_W    : width of the launch counter / program index
//             - DEF_PROG_STRIDE : default spacing between program entry points
//             - DEF_STACK_DEPTH : default return-stack depth
//  Revision : 1.0  initial release
// ============================================================================
package prog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_t;

    localparam int LAUNCH_CNT_W    = 4;
    localparam int DEF_PROG_STRIDE = 100;
    localparam int DEF_STACK_DEPTH = 4;

endpackage : prog_seq_pkg
`default_nettype wire

// File: rtl/prog_return_stack.sv
`default_nettype none
// ============================================================================
//  Module   : prog_return_stack
//  Purpose  : Small LIFO holding subroutine return addresses.
//  Ports    : Clk, Reset     - clock, synchronous active-high reset
//             clear          - empty the stack (takes priority over push/pop)
//             push/push_data - write push_data on top (ignored when full)
//             pop            - discard top entry (ignored when empty)
//             top_data       - current top entry (valid when !empty)
//             full, empty    - occupancy flags
//  Revision : 1.0  initial release
// ============================================================================
module prog_return_stack #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top_data,
    output logic         full,
    output logic         empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] c_depth = CW'(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_do_push;
    logic          w_do_pop;

    assign full      = (r_cnt == c_depth);
    assign empty     = (r_cnt == '0);
    assign w_wr_idx  = AW'(r_cnt);
    assign w_rd_idx  = AW'(r_cnt - CW'(1));
    assign w_do_push = push && !full && !clear;
    assign w_do_pop  = pop && !empty && !clear;
    assign top_data  = r_mem[w_rd_idx];

    // Entry storage needs no reset: nothing is readable until pushed.
    always_ff @(posedge Clk) begin
        if (w_do_push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            r_cnt <= '0;
        end else if (w_do_push) begin
            r_cnt <= r_cnt + CW'(1);
        end else if (w_do_pop) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

endmodule : prog_return_stack
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : prog_sequencer
//  Purpose  : Program counter sequencer. Launches up to NPROG programs (one
//             per Start high->low pulse) at entry points ProgIdx*PROG_STRIDE,
//             then steps the PC with stall/halt/branch/jump/call/return.
//  Config   : `define PROG_SEQ_CALL_STACK_EN enables Call/Ret with a return
//             stack and the StackErr flag; otherwise Call/Ret just increment.
//  Ports    : Clk, Reset (sync, active-high), Start (launch on falling edge),
//             Stall, Halt, BranchUp, BranchDown, Jump, Call, Ret, Offset,
//             AbsTarget -> ProgCtr, ProgIdx, Running, Done, StackErr
//  Revision : 1.0  initial release
// ============================================================================
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int L           = 10,
    parameter int OFFW        = 8,
    parameter int NPROG       = 3,
    parameter int PROG_STRIDE = DEF_PROG_STRIDE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    Start,
    input  logic                    Stall,
    input  logic                    Halt,
    input  logic                    BranchUp,
    input  logic                    BranchDown,
    input  logic                    Jump,
    input  logic                    Call,
    input  logic                    Ret,
    input  logic [OFFW-1:0]         Offset,
    input  logic [L-1:0]            AbsTarget,
    output logic [L-1:0]            ProgCtr,
    output logic [LAUNCH_CNT_W-1:0] ProgIdx,
    output logic                    Running,
    output logic                    Done,
    output logic                    StackErr
);

    localparam logic [LAUNCH_CNT_W-1:0] c_nprog = LAUNCH_CNT_W'(NPROG);

    seq_state_t              r_state, w_state_nxt;
    logic [L-1:0]            r_pc, w_pc_nxt;
    logic [LAUNCH_CNT_W-1:0] r_idx, w_idx_nxt;
    logic [LAUNCH_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic                    r_start;
    // Set once Start has been seen low; a rise only counts after that, so a
    // Start held high across reset release is not mistaken for a new request.
    logic                    r_low_seen;

    logic                    w_start_rise;
    logic                    w_start_fall;
    logic [L-1:0]            w_pc_inc;
    logic [L-1:0]            w_off;
    logic [31:0]             w_launch_prod;

    assign w_start_rise  = Start && !r_start && r_low_seen;
    assign w_start_fall  = !Start && r_start;
    assign w_pc_inc      = r_pc + L'(1);
    assign w_off         = L'(Offset);
    assign w_launch_prod = 32'(r_cnt) * PROG_STRIDE;

`ifdef PROG_SEQ_CALL_STACK_EN
    logic         r_stack_err, w_err_nxt;
    logic         w_stk_clear, w_stk_push, w_stk_pop;
    logic         w_stk_full, w_stk_empty;
    logic [L-1:0] w_stk_top;

    prog_return_stack #(
        .W     (L),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .Clk       (Clk),
        .Reset     (Reset),
        .clear     (w_stk_clear),
        .push      (w_stk_push),
        .pop       (w_stk_pop),
        .push_data (w_pc_inc),
        .top_data  (w_stk_top),
        .full      (w_stk_full),
        .empty     (w_stk_empty)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_stack_err <= 1'b0;
        end else begin
            r_stack_err <= w_err_nxt;
        end
    end

    assign StackErr = r_stack_err;
`else
    logic w_unused;
    assign w_unused = ^{Call, Ret, STACK_DEPTH};
    assign StackErr = 1'b0;
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_start    <= 1'b0;
            r_low_seen <= !Start;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_start    <= Start;
            r_low_seen <= r_low_seen || !Start;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
`ifdef PROG_SEQ_CALL_STACK_EN
        w_err_nxt   = r_stack_err;
        w_stk_clear = 1'b0;
        w_stk_push  = 1'b0;
        w_stk_pop   = 1'b0;
`endif
        if (w_start_rise) begin
            // A new request aborts whatever is happening, including a run.
            w_state_nxt = ST_ARMED;
        end else begin
            case (r_state)
                ST_ARMED: begin
                    if (w_start_fall) begin
                        if (r_cnt < c_nprog) begin
                            w_idx_nxt   = r_cnt;
                            w_pc_nxt    = w_launch_prod[L-1:0];
                            w_cnt_nxt   = r_cnt + LAUNCH_CNT_W'(1);
                            w_state_nxt = ST_RUN;
`ifdef PROG_SEQ_CALL_STACK_EN
                            w_stk_clear = 1'b1;
`endif
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    if (Stall) begin
                        w_pc_nxt = r_pc;
                    end else if (Halt) begin
                        w_state_nxt = ST_DONE;
                    end else if (Ret) begin
`ifdef PROG_SEQ_CALL_STACK_EN
                        if (w_stk_empty) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt  = w_stk_top;
                            w_stk_pop = 1'b1;
                        end
`else
                        w_pc_nxt = w_pc_inc;
`endif
                    end else if (Call) begin
`ifdef PROG_SEQ_CALL_STACK_EN
                        if (w_stk_full) begin
                            w_pc_nxt  = w_pc_inc;
                            w_err_nxt = 1'b1;
                        end else begin
                            w_pc_nxt   = AbsTarget;
                            w_stk_push = 1'b1;
                        end
`else
                        w_pc_nxt = w_pc_inc;
`endif
                    end else if (Jump) begin
                        w_pc_nxt = AbsTarget;
                    end else if (BranchUp) begin
                        w_pc_nxt = r_pc - w_off;
                    end else if (BranchDown) begin
                        w_pc_nxt = r_pc + w_off;
                    end else begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    assign ProgCtr = r_pc;
    assign ProgIdx = r_idx;
    assign Running = (r_state == ST_RUN);
    assign Done    = (r_state == ST_DONE);

endmodule : prog_sequencer
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_prog_sequencer
//  Purpose  : Self-checking bench for prog_sequencer: directed scenarios plus
//             randomized traffic, all compared against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_prog_sequencer;

    localparam int L      = 10;
    localparam int OFFW   = 8;
    localparam int NPROG  = 3;
    localparam int STRIDE = 100;
    localparam int DEPTH  = 4;
    localparam int MOD    = 1 << L;
`ifdef PROG_SEQ_CALL_STACK_EN
    localparam bit STACK_ON = 1'b1;
`else
    localparam bit STACK_ON = 1'b0;
`endif

    logic            Clk = 1'b0;
    logic            Reset, Start, Stall, Halt, BranchUp, BranchDown;
    logic            Jump, Call, Ret;
    logic [OFFW-1:0] Offset;
    logic [L-1:0]    AbsTarget;
    logic [L-1:0]    ProgCtr;
    logic [3:0]      ProgIdx;
    logic            Running, Done, StackErr;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    prog_sequencer #(
        .L           (L),
        .OFFW        (OFFW),
        .NPROG       (NPROG),
        .PROG_STRIDE (STRIDE),
        .STACK_DEPTH (DEPTH)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Stall      (Stall),
        .Halt       (Halt),
        .BranchUp   (BranchUp),
        .BranchDown (BranchDown),
        .Jump       (Jump),
        .Call       (Call),
        .Ret        (Ret),
        .Offset     (Offset),
        .AbsTarget  (AbsTarget),
        .ProgCtr    (ProgCtr),
        .ProgIdx    (ProgIdx),
        .Running    (Running),
        .Done       (Done),
        .StackErr   (StackErr)
    );

    // ---------------- behavioural model ----------------
    typedef enum int {P_IDLE, P_ARMED, P_RUN, P_DONE} phase_t;
    phase_t m_phase;
    int     m_pc, m_idx, m_launches;
    bit     m_prev_start, m_need_low, m_err;
    int     m_stack[$];

    task automatic model_edge();
        bit rise, fall;
        int off;
        if (Reset) begin
            m_phase = P_IDLE; m_pc = 0; m_idx = 0; m_launches = 0;
            m_prev_start = 0; m_need_low = Start; m_err = 0;
            m_stack.delete();
            return;
        end
        rise = Start && !m_prev_start && !m_need_low;
        fall = !Start && m_prev_start;
        m_prev_start = Start;
        if (!Start) m_need_low = 0;
        off = int'(Offset);
        if (rise) begin
            m_phase = P_ARMED;
        end else if (m_phase == P_ARMED) begin
            if (fall) begin
                if (m_launches < NPROG) begin
                    m_idx = m_launches;
                    m_pc = (m_launches * STRIDE) % MOD;
                    m_launches++;
                    m_stack.delete();
                    m_phase = P_RUN;
                end else begin
                    m_phase = P_DONE;
                end
            end
        end else if (m_phase == P_RUN) begin
            if (Stall) begin
                // hold
            end else if (Halt) begin
                m_phase = P_DONE;
            end else if (Ret) begin
                if (STACK_ON && m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_pc = (m_pc + 1) % MOD;
                    if (STACK_ON) m_err = 1;
                end
            end else if (Call) begin
                if (STACK_ON && m_stack.size() < DEPTH) begin
                    m_stack.push_back((m_pc + 1) % MOD);
                    m_pc = int'(AbsTarget);
                end else begin
                    m_pc = (m_pc + 1) % MOD;
                    if (STACK_ON) m_err = 1;
                end
            end else if (Jump) begin
                m_pc = int'(AbsTarget);
            end else if (BranchUp) begin
                m_pc = (m_pc - off + MOD) % MOD;
            end else if (BranchDown) begin
                m_pc = (m_pc + off) % MOD;
            end else begin
                m_pc = (m_pc + 1) % MOD;
            end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ProgCtr"},  32'(ProgCtr),  m_pc);
        chk({tag, ".ProgIdx"},  32'(ProgIdx),  m_idx);
        chk({tag, ".Running"},  32'(Running),  32'(m_phase == P_RUN));
        chk({tag, ".Done"},     32'(Done),     32'(m_phase == P_DONE));
        chk({tag, ".StackErr"}, 32'(StackErr), 32'(m_err));
    endtask

    task automatic tick(input string tag);
        @(posedge Clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic clr_ctl();
        Stall = 0; Halt = 0; BranchUp = 0; BranchDown = 0;
        Jump = 0; Call = 0; Ret = 0;
    endtask

    task automatic launch(input string tag);
        Start = 1; tick({tag, "_rise"});
        Start = 0; tick({tag, "_fall"});
    endtask

    task automatic jump_to(input int tgt);
        Jump = 1; AbsTarget = L'(tgt); tick("jump"); Jump = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        Reset = 1; Start = 0; Offset = '0; AbsTarget = '0;
        clr_ctl();
        tick("reset0");
        tick("reset1");
        chk("reset_pc", 32'(ProgCtr), 0);
        chk("reset_running", 32'(Running), 0);
        Reset = 0;
        tick("idle");

        // Start held three cycles: PC frozen, launch on release.
        Start = 1;
        repeat (3) begin
            tick("armed_hold");
            chk("armed_pc_const", 32'(ProgCtr), 0);
        end
        Start = 0;
        tick("launch0");
        chk("launch0_running", 32'(Running), 1);
        chk("launch0_idx", 32'(ProgIdx), 0);

        // Relative branches with wrap, and stall priority.
        jump_to(20);
        BranchDown = 1; Offset = 8'd5; tick("bdown"); clr_ctl();
        chk("bdown_25", 32'(ProgCtr), 25);
        BranchUp = 1; Offset = 8'd30; tick("bup_wrap"); clr_ctl();
        chk("bup_1019", 32'(ProgCtr), 1019);
        Stall = 1; Jump = 1; AbsTarget = 10'd3; tick("stall_jump"); clr_ctl();
        chk("stall_hold", 32'(ProgCtr), 1019);

        // Halt then relaunches up to exhaustion.
        jump_to(6);
        tick("inc7");
        Halt = 1; tick("halt"); clr_ctl();
        chk("halt_done", 32'(Done), 1);
        chk("halt_pc7", 32'(ProgCtr), 7);
        launch("launch1");
        chk("launch1_pc", 32'(ProgCtr), 100);
        chk("launch1_idx", 32'(ProgIdx), 1);
        Halt = 1; tick("halt1"); clr_ctl();
        launch("launch2");
        chk("launch2_pc", 32'(ProgCtr), 200);
        Halt = 1; tick("halt2"); clr_ctl();
        launch("launch3");
        chk("launch3_done", 32'(Done), 1);
        chk("launch3_pc", 32'(ProgCtr), 200);

        // Call / return.
        Reset = 1; tick("rst_stack"); Reset = 0;
        launch("stk_launch");
        jump_to(10);
        Call = 1; AbsTarget = 10'd50; tick("call50"); clr_ctl();
        Ret = 1; tick("ret"); clr_ctl();
`ifdef PROG_SEQ_CALL_STACK_EN
        chk("ret_11", 32'(ProgCtr), 11);
`endif
        for (int i = 1; i <= 5; i++) begin
            Call = 1; AbsTarget = L'(i * 100); tick("nest_call"); clr_ctl();
        end
`ifdef PROG_SEQ_CALL_STACK_EN
        chk("overflow_pc", 32'(ProgCtr), 401);
        chk("overflow_err", 32'(StackErr), 1);
`endif
        for (int i = 0; i < 5; i++) begin
            Ret = 1; tick("unwind"); clr_ctl();
        end
`ifdef PROG_SEQ_CALL_STACK_EN
        chk("underflow_pc", 32'(ProgCtr), 13);
        chk("underflow_err", 32'(StackErr), 1);
`endif
        Call = 1; Ret = 1; AbsTarget = 10'd77; tick("call_ret"); clr_ctl();

        // Reset mid-run with Start held high.
        jump_to(333);
        chk("pc333", 32'(ProgCtr), 333);
        Start = 1; Reset = 1; tick("rst_mid"); Reset = 0;
        chk("rst_mid_pc", 32'(ProgCtr), 0);
        repeat (3) tick("start_held");
        Start = 0;
        repeat (2) tick("no_launch");
        chk("still_idle", 32'(Running), 0);
        launch("fresh");
        chk("fresh_running", 32'(Running), 1);
        chk("fresh_pc", 32'(ProgCtr), 0);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            Reset      = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 11) == 0) Start = !Start;
            Stall      = ($urandom_range(0, 7) == 0);
            Halt       = ($urandom_range(0, 39) == 0);
            Ret        = ($urandom_range(0, 5) == 0);
            Call       = ($urandom_range(0, 5) == 0);
            Jump       = ($urandom_range(0, 5) == 0);
            BranchUp   = ($urandom_range(0, 5) == 0);
            BranchDown = ($urandom_range(0, 5) == 0);
            Offset     = OFFW'($urandom);
            AbsTarget  = L'($urandom);
            tick("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_prog_sequencer
`default_nettype wire
